// File: rtl/sort_pkg.sv
// Shared definitions for the sorter family: FSM state encoding and a
// constant-foldable log2 helper used to size index fields.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, never less than 1 so an index field always has a bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sort_oet_n_if.sv
// Handshake bundle between a vector producer / result consumer and the
// sorter. The master side is the environment, the slave side the sorter.
interface sort_oet_n_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  localparam int IDXW = sort_pkg::clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 in_desc;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*WIDTH-1:0]   out_data;
  logic [N*IDXW-1:0]    out_idx;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_desc, out_ready,
    input  in_ready, out_valid, out_data, out_idx, busy
  );

  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
    output in_ready, out_valid, out_data, out_idx, busy
  );

endinterface

// File: rtl/sort_cas.sv
// Compare-exchange cell. 'hi' is the element that belongs at the lower
// position of the pair for the requested direction, 'lo' the other one.
// Elements swap only when strictly out of order, which keeps ties stable.
module sort_cas #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0,
  parameter int IDXW   = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IDXW-1:0]  ia,
  input  logic [IDXW-1:0]  ib,
  input  logic             desc,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [IDXW-1:0]  ihi,
  output logic [IDXW-1:0]  ilo
);

  logic a_lt_b;
  logic a_gt_b;
  logic swap;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      assign sa     = a;
      assign sb     = b;
      assign a_lt_b = (sa < sb);
      assign a_gt_b = (sa > sb);
    end else begin : g_unsigned
      assign a_lt_b = (a < b);
      assign a_gt_b = (a > b);
    end
  endgenerate

  assign swap = desc ? a_lt_b : a_gt_b;
  assign hi   = swap ? b  : a;
  assign lo   = swap ? a  : b;
  assign ihi  = swap ? ib : ia;
  assign ilo  = swap ? ia : ib;

endmodule

// File: rtl/sort_oet_n.sv
// Iterative odd-even transposition sorter: one compare-exchange layer per
// clock over N phases, carrying each element's original input index.
module sort_oet_n
  import sort_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N      = 4,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  sort_oet_n_if.slave   bus
);

  localparam int IDXW = clog2(N);
  localparam logic [IDXW-1:0] LAST_PHASE = IDXW'(N - 1);

  state_e          state_q;
  state_e          state_d;
  logic [IDXW-1:0] phase_q;
  logic            desc_q;
  logic            accept;

  logic [WIDTH-1:0] data_q  [N];
  logic [IDXW-1:0]  idx_q   [N];
  logic [WIDTH-1:0] data_nx [N];
  logic [IDXW-1:0]  idx_nx  [N];

  logic [WIDTH-1:0] hi_w  [N-1];
  logic [WIDTH-1:0] lo_w  [N-1];
  logic [IDXW-1:0]  ihi_w [N-1];
  logic [IDXW-1:0]  ilo_w [N-1];

  assign accept        = (state_q == IDLE) && bus.in_valid;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);

  // Cell k always looks at elements (k, k+1); the phase parity decides
  // which cells actually write back.
  generate
    for (genvar k = 0; k < N - 1; k++) begin : g_cas
      sort_cas #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED),
        .IDXW   (IDXW)
      ) u_cas (
        .a    (data_q[k]),
        .b    (data_q[k+1]),
        .ia   (idx_q[k]),
        .ib   (idx_q[k+1]),
        .desc (desc_q),
        .hi   (hi_w[k]),
        .lo   (lo_w[k]),
        .ihi  (ihi_w[k]),
        .ilo  (ilo_w[k])
      );
    end

    for (genvar j = 0; j < N; j++) begin : g_pack
      assign bus.out_data[WIDTH*j +: WIDTH] = data_q[j];
      assign bus.out_idx[IDXW*j +: IDXW]    = idx_q[j];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, N phases in SORT, hold until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)         state_d = SORT;
      SORT:    if (phase_q == LAST_PHASE) state_d = DONE;
      DONE:    if (bus.out_ready)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase counter: cleared on accept, advances once per SORT clock.
  always_ff @(posedge clk) begin
    if (rst)                   phase_q <= '0;
    else if (accept)           phase_q <= '0;
    else if (state_q == SORT)  phase_q <= phase_q + 1'b1;
  end

  // One transposition layer: even phases use cells 0,2,..; odd phases 1,3,..
  always_comb begin
    for (int j = 0; j < N; j++) begin
      data_nx[j] = data_q[j];
      idx_nx[j]  = idx_q[j];
    end
    for (int k = 0; k < N - 1; k++) begin
      if (k[0] == phase_q[0]) begin
        data_nx[k]   = hi_w[k];
        data_nx[k+1] = lo_w[k];
        idx_nx[k]    = ihi_w[k];
        idx_nx[k+1]  = ilo_w[k];
      end
    end
  end

  // Element, index and direction registers: load on accept, permute in SORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_q <= 1'b0;
      for (int j = 0; j < N; j++) begin
        data_q[j] <= '0;
        idx_q[j]  <= '0;
      end
    end else if (accept) begin
      desc_q <= bus.in_desc;
      for (int j = 0; j < N; j++) begin
        data_q[j] <= bus.in_data[WIDTH*j +: WIDTH];
        idx_q[j]  <= IDXW'(j);
      end
    end else if (state_q == SORT) begin
      for (int j = 0; j < N; j++) begin
        data_q[j] <= data_nx[j];
        idx_q[j]  <= idx_nx[j];
      end
    end
  end

endmodule

// File: tb/tb_sort_oet_n.sv
// Bench for sort_oet_n: an unsigned and a signed instance run in lockstep on
// the same stimulus and are compared against a stable-sort reference model.
module tb_sort_oet_n;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int IDXW  = 2;
  localparam int DW    = N * WIDTH;
  localparam int IW    = N * IDXW;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_desc   = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;

  int n_chk  = 0;
  int n_fail = 0;

  sort_oet_n_if #(.WIDTH(WIDTH), .N(N)) bus_u ();
  sort_oet_n_if #(.WIDTH(WIDTH), .N(N)) bus_s ();

  assign bus_u.in_valid  = in_valid;
  assign bus_u.in_data   = in_data;
  assign bus_u.in_desc   = in_desc;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.in_desc   = in_desc;
  assign bus_s.out_ready = out_ready;

  sort_oet_n #(.WIDTH(WIDTH), .N(N), .SIGNED(0)) u_dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bus_u)
  );

  sort_oet_n #(.WIDTH(WIDTH), .N(N), .SIGNED(1)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Stable sort by key: an element moves ahead of another only when its key
  // is strictly better in the requested direction.
  function automatic void model(input logic [DW-1:0] data, input logic desc, input bit sgn,
                                output logic [DW-1:0] od, output logic [IW-1:0] oi);
    longint key [N];
    int     ord [N];
    logic [WIDTH-1:0] e;
    int t;
    for (int i = 0; i < N; i++) begin
      e = data[WIDTH*i +: WIDTH];
      if (sgn) key[i] = longint'($signed(e));
      else     key[i] = longint'({48'd0, e});
      ord[i] = i;
    end
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (key[ord[j]] > key[ord[j-1]]) : (key[ord[j]] < key[ord[j-1]])) begin
          t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
        end
      end
    end
    od = '0;
    oi = '0;
    for (int i = 0; i < N; i++) begin
      od[WIDTH*i +: WIDTH] = data[WIDTH*ord[i] +: WIDTH];
      oi[IDXW*i +: IDXW]   = IDXW'(ord[i]);
    end
  endfunction

  // Present one vector, then wait (bounded) for the result and check latency
  // and contents of both instances. Leaves both in DONE.
  task automatic xact(input logic [DW-1:0] data, input logic desc);
    logic [DW-1:0] ed;
    logic [IW-1:0] ei;
    int cnt;
    cnt = 0;
    while (!bus_u.in_ready && cnt < 50) begin
      @(posedge clk); @(negedge clk); cnt++;
    end
    chk("in_ready before accept", {63'd0, bus_u.in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_desc  = desc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'({$urandom, $urandom});
    in_desc  = ~desc;
    cnt = 0;
    while (!bus_u.out_valid && cnt < 50) begin
      @(posedge clk); cnt++;
      @(negedge clk);
    end
    chk("latency", 64'(cnt), 64'(N));
    chk("s out_valid", {63'd0, bus_s.out_valid}, 64'd1);
    chk("busy in DONE", {63'd0, bus_u.busy}, 64'd1);
    model(data, desc, 1'b0, ed, ei);
    chk("u out_data", bus_u.out_data, ed);
    chk("u out_idx", 64'(bus_u.out_idx), 64'(ei));
    model(data, desc, 1'b1, ed, ei);
    chk("s out_data", bus_s.out_data, ed);
    chk("s out_idx", 64'(bus_s.out_idx), 64'(ei));
  endtask

  // Consume the result with a new vector offered on the same cycle; it must
  // not be captured.
  task automatic consume();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = DW'({$urandom, $urandom});
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid after consume", {63'd0, bus_u.out_valid}, 64'd0);
    chk("s out_valid after consume", {63'd0, bus_s.out_valid}, 64'd0);
    chk("busy after consume", {62'd0, bus_u.busy, bus_s.busy}, 64'd0);
    chk("in_ready after consume", {63'd0, bus_u.in_ready}, 64'd1);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_i;

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", {63'd0, bus_u.in_ready}, 64'd1);
    chk("reset out_valid", {62'd0, bus_u.out_valid, bus_s.out_valid}, 64'd0);
    chk("reset busy", {62'd0, bus_u.busy, bus_s.busy}, 64'd0);
    chk("reset out_data", bus_u.out_data, 64'd0);
    chk("reset out_idx", 64'(bus_u.out_idx), 64'd0);

    // Descending, unsigned
    xact({16'h0008, 16'h0001, 16'h0010, 16'h0003}, 1'b1);
    chk("desc data", bus_u.out_data, {16'h0001, 16'h0003, 16'h0008, 16'h0010});
    chk("desc idx", 64'(bus_u.out_idx), 64'({2'd2, 2'd0, 2'd3, 2'd1}));

    // Backpressure with a competing vector offered
    hold_d   = bus_u.out_data;
    hold_i   = bus_u.out_idx;
    in_valid = 1'b1;
    in_data  = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    in_desc  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp out_data", bus_u.out_data, {16'h0001, 16'h0003, 16'h0008, 16'h0010});
      chk("bp out_idx", 64'(bus_u.out_idx), 64'({2'd2, 2'd0, 2'd3, 2'd1}));
      chk("bp in_ready", {63'd0, bus_u.in_ready}, 64'd0);
      chk("bp out_valid", {63'd0, bus_u.out_valid}, 64'd1);
    end
    chk("bp hold data", bus_u.out_data, hold_d);
    chk("bp hold idx", 64'(bus_u.out_idx), 64'(hold_i));
    in_valid = 1'b0;
    consume();

    // Ascending, same vector
    xact({16'h0008, 16'h0001, 16'h0010, 16'h0003}, 1'b0);
    chk("asc data", bus_u.out_data, {16'h0010, 16'h0008, 16'h0003, 16'h0001});
    chk("asc idx", 64'(bus_u.out_idx), 64'({2'd1, 2'd3, 2'd0, 2'd2}));
    consume();

    // Ties keep input order
    xact({16'h0005, 16'h0002, 16'h0005, 16'h0005}, 1'b1);
    chk("tie data", bus_u.out_data, {16'h0002, 16'h0005, 16'h0005, 16'h0005});
    chk("tie idx", 64'(bus_u.out_idx), 64'({2'd2, 2'd3, 2'd1, 2'd0}));
    consume();

    // Signed compare, descending
    xact({16'h0000, 16'h8000, 16'h0001, 16'hFFFF}, 1'b1);
    chk("signed data", bus_s.out_data, {16'h8000, 16'hFFFF, 16'h0000, 16'h0001});
    chk("signed idx", 64'(bus_s.out_idx), 64'({2'd2, 2'd0, 2'd3, 2'd1}));
    consume();

    // Reset on the second SORT clock
    in_valid = 1'b1;
    in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    in_desc  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort out_valid", {62'd0, bus_u.out_valid, bus_s.out_valid}, 64'd0);
    chk("abort busy", {62'd0, bus_u.busy, bus_s.busy}, 64'd0);
    chk("abort in_ready", {62'd0, bus_u.in_ready, bus_s.in_ready}, 64'd3);
    chk("abort out_data", bus_u.out_data, 64'd0);
    chk("abort out_idx", 64'(bus_u.out_idx), 64'd0);
    xact({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1);
    chk("post-abort data", bus_u.out_data, {16'h0001, 16'h0002, 16'h0003, 16'h0004});
    consume();

    // Randomized vectors, some from a narrow range to force ties
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r % 3 == 0) v[WIDTH*i +: WIDTH] = WIDTH'($urandom_range(0, 3));
        else if (r % 3 == 1) v[WIDTH*i +: WIDTH] = WIDTH'($urandom_range(16'h7FFE, 16'h8001));
        else v[WIDTH*i +: WIDTH] = WIDTH'($urandom);
      end
      xact(v, 1'($urandom_range(0, 1)));
      hold_d = bus_u.out_data;
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        @(posedge clk);
        @(negedge clk);
        chk("rand hold", bus_u.out_data, hold_d);
      end
      consume();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
